systolic_array_ctrl: RTL and testbench

Sequencer for a ROWS x COLS weight-stationary systolic array. On `start` it loads one weight per PE row from weight memory, then streams `num_vectors` activation vectors from activation memory. It generates the per-anti-diagonal `valid` wavefront that drives every PE, flags when each column's bottom `psum_out` holds a finished result, and pulses `done`. It sits between the host/command logic and the PE grid plus its input skew buffers.

---
 rtl/systolic_array_ctrl.sv | 149 ++++++++++++++
 tb/tb_systolic_array_ctrl.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/systolic_array_ctrl.sv
// Sequencer for a weight-stationary ROWS x COLS systolic array: weight load, activation stream, wavefront and drain.
// Optional feature: SA_CTRL_WEIGHT_REUSE_EN adds reuse_weights to skip the weight load phase.
module systolic_array_ctrl #(
  parameter int ROWS        = 4,
  parameter int COLS        = 4,
  parameter int MAX_VECTORS = 16,
  localparam int AW  = $clog2(MAX_VECTORS),
  localparam int NW  = $clog2(MAX_VECTORS + 1),
  localparam int WAW = $clog2(ROWS),
  localparam int DW  = ROWS + COLS - 1
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            start,
  input  logic [NW-1:0]   num_vectors,
`ifdef SA_CTRL_WEIGHT_REUSE_EN
  input  logic            reuse_weights,
`endif
  input  logic            hold,
  output logic            busy,
  output logic            done,
  output logic            wt_rd_en,
  output logic [WAW-1:0]  wt_addr,
  output logic [ROWS-1:0] load_weight_row,
  output logic            act_rd_en,
  output logic [AW-1:0]   act_addr,
  output logic [DW-1:0]   valid_diag,
  output logic [COLS-1:0] res_valid,
  output logic [2:0]      dbg_state
);

  localparam int MAXC = (ROWS > MAX_VECTORS) ? ROWS : MAX_VECTORS;
  localparam int CW   = $clog2(MAXC + 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LOAD_W = 3'd1,
    S_STREAM = 3'd2,
    S_DRAIN  = 3'd3,
    S_DONE   = 3'd4
  } state_t;

  state_t          state;
  logic [CW-1:0]   cnt;
  logic [NW-1:0]   n_q;
  logic [DW-1:0]   diag_q;
  logic [COLS-1:0] res_q;

  logic            run;
  logic            stall;
  logic            wt_raw;
  logic            ld_raw;
  logic            act_raw;
  logic            reuse;
  logic [DW-1:0]   nxt_diag;
  logic [COLS-1:0] nxt_res;
  logic [NW-1:0]   n_clamp;

`ifdef SA_CTRL_WEIGHT_REUSE_EN
  assign reuse = reuse_weights;
`else
  assign reuse = 1'b0;
`endif

  // start is a one-shot request taken only in IDLE (no ready/backpressure, never queued);
  // hold stalls the whole sequencer while busy and masks every strobe in that same cycle.
  assign run     = (state == S_LOAD_W) || (state == S_STREAM) || (state == S_DRAIN);
  assign stall   = run & hold;
  assign wt_raw  = (state == S_LOAD_W) && (cnt < CW'(ROWS));
  assign ld_raw  = (state == S_LOAD_W) && (cnt != '0);
  assign act_raw = (state == S_STREAM);
  assign n_clamp = (num_vectors > NW'(MAX_VECTORS)) ? NW'(MAX_VECTORS) : num_vectors;

  // The bottom COLS taps of the diagonal chain feed the result-valid stage.
  assign nxt_diag = {diag_q[DW-2:0], act_raw};
  assign nxt_res  = diag_q[DW-1:ROWS-1];

  assign busy            = run;
  assign done            = (state == S_DONE);
  assign wt_rd_en        = wt_raw & ~stall;
  assign wt_addr         = wt_raw ? cnt[WAW-1:0] : '0;
  assign load_weight_row = (ld_raw && !stall) ? (ROWS'(1) << (cnt - CW'(1))) : '0;
  assign act_rd_en       = act_raw & ~stall;
  assign act_addr        = act_raw ? cnt[AW-1:0] : '0;
  assign valid_diag      = stall ? '0 : diag_q;
  assign res_valid       = stall ? '0 : res_q;
  assign dbg_state       = state;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state  <= S_IDLE;
      cnt    <= '0;
      n_q    <= '0;
      diag_q <= '0;
      res_q  <= '0;
    end else begin
      if (run && !hold) begin
        diag_q <= nxt_diag;
        res_q  <= nxt_res;
      end
      case (state)
        S_IDLE: begin
          if (start) begin
            if (num_vectors == '0) begin
              state <= S_DONE;
            end else begin
              n_q   <= n_clamp;
              cnt   <= '0;
              state <= reuse ? S_STREAM : S_LOAD_W;
            end
          end
        end
        S_LOAD_W: begin
          if (!hold) begin
            if (cnt == CW'(ROWS)) begin
              cnt   <= '0;
              state <= S_STREAM;
            end else begin
              cnt <= cnt + CW'(1);
            end
          end
        end
        S_STREAM: begin
          if (!hold) begin
            if (cnt + CW'(1) == CW'(n_q)) begin
              cnt   <= '0;
              state <= S_DRAIN;
            end else begin
              cnt <= cnt + CW'(1);
            end
          end
        end
        S_DRAIN: begin
          // Leave once the last result-valid cycle has been shown.
          if (!hold && nxt_diag == '0 && nxt_res == '0) begin
            state <= S_DONE;
          end
        end
        S_DONE: begin
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_systolic_array_ctrl.sv
// Self-checking bench for systolic_array_ctrl: per-cycle reference built from the job timing rules,
// with directed jobs from the test plan plus randomized jobs, holds and stray start requests.
module tb_systolic_array_ctrl;

  localparam int ROWS = 4;
  localparam int COLS = 4;
  localparam int MAXV = 16;
  localparam int NW   = $clog2(MAXV + 1);
  localparam int AW   = $clog2(MAXV);
  localparam int WAW  = $clog2(ROWS);
  localparam int DW   = ROWS + COLS - 1;
  localparam int CTW  = 3 + ROWS + 1 + DW + COLS;

  logic            clk = 1'b0;
  logic            reset_n = 1'b0;
  logic            start = 1'b0;
  logic [NW-1:0]   num_vectors = '0;
  logic            hold = 1'b0;
`ifdef SA_CTRL_WEIGHT_REUSE_EN
  logic            reuse_weights = 1'b0;
`endif
  logic            busy;
  logic            done;
  logic            wt_rd_en;
  logic [WAW-1:0]  wt_addr;
  logic [ROWS-1:0] load_weight_row;
  logic            act_rd_en;
  logic [AW-1:0]   act_addr;
  logic [DW-1:0]   valid_diag;
  logic [COLS-1:0] res_valid;
  logic [2:0]      dbg_state;

  int n_checks = 0;
  int n_fail   = 0;

  logic [CTW-1:0] exp_q[$];
  logic [7:0]     addr_q[$];
  logic           hold_q[$];

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  systolic_array_ctrl #(.ROWS(ROWS), .COLS(COLS), .MAX_VECTORS(MAXV)) dut (
    .clk             (clk),
    .reset_n         (reset_n),
    .start           (start),
    .num_vectors     (num_vectors),
`ifdef SA_CTRL_WEIGHT_REUSE_EN
    .reuse_weights   (reuse_weights),
`endif
    .hold            (hold),
    .busy            (busy),
    .done            (done),
    .wt_rd_en        (wt_rd_en),
    .wt_addr         (wt_addr),
    .load_weight_row (load_weight_row),
    .act_rd_en       (act_rd_en),
    .act_addr        (act_addr),
    .valid_diag      (valid_diag),
    .res_valid       (res_valid),
    .dbg_state       (dbg_state)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Expected control outputs for active index a (cycles since start, held cycles not counted).
  function automatic logic [CTW-1:0] model(input int a, input int s, input int nc, input bit held);
    logic            busy_e, done_e, wt_e, act_e;
    logic [ROWS-1:0] ld_e;
    logic [DW-1:0]   vd_e;
    logic [COLS-1:0] rs_e;
    int last;
    last   = (nc == 0) ? 0 : s + nc + ROWS + COLS - 1;
    busy_e = (nc > 0) && (a >= 1) && (a <= last);
    done_e = (a == last + 1);
    wt_e   = !held && (nc > 0) && (s > 1) && (a >= 1) && (a <= ROWS);
    ld_e   = '0;
    if (!held && (nc > 0) && (s > 1) && (a >= 2) && (a <= ROWS + 1)) ld_e[a-2] = 1'b1;
    act_e  = !held && (nc > 0) && (a >= s) && (a <= s + nc - 1);
    for (int d = 0; d < DW; d++)
      vd_e[d] = !held && (nc > 0) && (a >= s + 1 + d) && (a <= s + nc + d);
    for (int c = 0; c < COLS; c++)
      rs_e[c] = !held && (nc > 0) && (a >= s + ROWS + c + 1) && (a <= s + ROWS + c + nc);
    return {busy_e, done_e, wt_e, ld_e, act_e, vd_e, rs_e};
  endfunction

  // ---------------- driver ----------------
  // Runs one job from its cycle 0; returns the observed done cycle (-1 if none).
  task automatic run_job(input int n, input bit reuse, input int hold_pct,
                         input logic [63:0] hold_mask, input int poke_cyc,
                         input bit rand_poke, input int abort_at, output int done_cyc);
    int s, nc, last, a, cyc, i;
    bit hd, held;
    logic [CTW-1:0] e;
    logic [7:0] ea;
    logic [CTW-1:0] obs;
    nc   = (n > MAXV) ? MAXV : n;
    s    = reuse ? 1 : ROWS + 2;
    last = (nc == 0) ? 0 : s + nc + ROWS + COLS - 1;
    exp_q.delete(); addr_q.delete(); hold_q.delete();
    a = 0;
    cyc = 0;
    while (a <= last + 1) begin
      hd   = (cyc < 64 && hold_mask[cyc]) || ($urandom_range(0, 99) < hold_pct);
      held = hd && (a >= 1) && (a <= last);
      e    = model(a, s, nc, held);
      ea   = {e[CTW-3], WAW'(a - 1), 1'b0, AW'(a - s)};
      ea[AW] = e[DW + COLS];
      exp_q.push_back(e);
      addr_q.push_back(ea);
      hold_q.push_back(hd);
      if (!held) a++;
      cyc++;
    end
    done_cyc = -1;
    i = 0;
    while (exp_q.size() > 0) begin
      e  = exp_q.pop_front();
      ea = addr_q.pop_front();
      hold  = hold_q.pop_front();
      start = (i == 0) || (i == poke_cyc) || (rand_poke && $urandom_range(0, 3) == 0);
      num_vectors = (i == 0) ? NW'(n) : NW'($urandom_range(0, MAXV + 3));
`ifdef SA_CTRL_WEIGHT_REUSE_EN
      reuse_weights = (i == 0) ? reuse : 1'($urandom_range(0, 1));
`endif
      if (i == abort_at) begin
        #2 reset_n = 1'b0;
        #1;
        check("rst_busy", 32'(busy), 0);
        check("rst_done", 32'(done), 0);
        check("rst_strobes", 32'({wt_rd_en, load_weight_row, act_rd_en}), 0);
        check("rst_wave", 32'({valid_diag, res_valid}), 0);
        check("rst_addr", 32'({wt_addr, act_addr}), 0);
        start = 1'b0;
        hold  = 1'b0;
        repeat (2) begin
          @(negedge clk);
          check("rst_no_done", 32'({busy, done}), 0);
        end
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        exp_q.delete(); addr_q.delete(); hold_q.delete();
        return;
      end
      @(negedge clk);
      obs = {busy, done, wt_rd_en, load_weight_row, act_rd_en, valid_diag, res_valid};
      check($sformatf("ctrl_c%0d", i), 32'(obs), 32'(e));
      if (ea[7]) check($sformatf("wt_addr_c%0d", i), 32'(wt_addr), 32'(ea[6:5]));
      if (ea[AW]) check($sformatf("act_addr_c%0d", i), 32'(act_addr), 32'(ea[AW-1:0]));
      if (!e[CTW-1]) check($sformatf("idle_addr_c%0d", i), 32'({wt_addr, act_addr}), 0);
      if (done === 1'b1 && done_cyc < 0) done_cyc = i;
      @(posedge clk);
      #1;
      start = 1'b0;
      i++;
    end
    hold = 1'b0;
  endtask

  // ---------------- scenario ----------------
  initial begin
    int dc;
    logic [63:0] m;
    reset_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_outputs", 32'({busy, done, wt_rd_en, load_weight_row, act_rd_en, valid_diag, res_valid}), 0);
    check("reset_state", 32'(dbg_state), 0);
    reset_n = 1'b1;
    @(posedge clk);
    #1;

    run_job(3, 1'b0, 0, 64'd0, -1, 1'b0, -1, dc);
    check("base_done_cycle", 32'(dc), 17);

    m = 64'd0; m[7] = 1'b1; m[12] = 1'b1;
    run_job(3, 1'b0, 0, m, -1, 1'b0, -1, dc);
    check("hold_done_cycle", 32'(dc), 19);

    run_job(0, 1'b0, 0, 64'd0, -1, 1'b0, -1, dc);
    check("zero_done_cycle", 32'(dc), 1);

    run_job(3, 1'b0, 0, 64'd0, 5, 1'b0, -1, dc);
    check("poke_done_cycle", 32'(dc), 17);
    run_job(3, 1'b0, 0, 64'd0, -1, 1'b0, -1, dc);
    check("b2b_done_cycle", 32'(dc), 17);

    run_job(3, 1'b0, 0, 64'd0, -1, 1'b0, 9, dc);
    check("abort_no_done", 32'(dc), 32'hffff_ffff);
    run_job(3, 1'b0, 0, 64'd0, -1, 1'b0, -1, dc);
    check("post_reset_done_cycle", 32'(dc), 17);

    run_job(MAXV, 1'b0, 0, 64'd0, -1, 1'b0, -1, dc);
    check("max_done_cycle", 32'(dc), ROWS + 2 + MAXV + ROWS + COLS);
    run_job(MAXV + 3, 1'b0, 0, 64'd0, -1, 1'b0, -1, dc);
    check("clamp_done_cycle", 32'(dc), ROWS + 2 + MAXV + ROWS + COLS);
    run_job(1, 1'b0, 0, 64'd0, -1, 1'b0, -1, dc);
    check("one_done_cycle", 32'(dc), ROWS + 3 + ROWS + COLS);

`ifdef SA_CTRL_WEIGHT_REUSE_EN
    run_job(3, 1'b1, 0, 64'd0, -1, 1'b0, -1, dc);
    check("reuse_done_cycle", 32'(dc), 12);
`endif

    for (int j = 0; j < 25; j++) begin
      int n;
      bit r;
      n = $urandom_range(0, MAXV + 3);
`ifdef SA_CTRL_WEIGHT_REUSE_EN
      r = 1'($urandom_range(0, 1));
`else
      r = 1'b0;
`endif
      run_job(n, r, 25, 64'd0, -1, 1'b1, -1, dc);
      check($sformatf("rand%0d_done_seen", j), 32'(dc >= 1), 1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
